// File: rtl/ram_1r1w_ext.sv
// ram_1r1w_ext: parametrised 1R1W distributed RAM with a self-clearing init sweep.
//   After reset the whole array is swept to INIT_VAL. The sweep takes DEPTH cycles,
//   and init_done rises on the edge that writes the last word. User traffic is
//   ignored until then.
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   init_done     - high once the init sweep has completed
//   wr/wmask/waddr/din - write port; wmask has one bit per WE_GRAN-bit lane
//   rd/raddr      - read request
//   dout/dout_valid - read data and its one-cycle qualifier after RD_LATENCY cycles
module ram_1r1w_ext #(
    parameter int unsigned     WIDTH       = 64,
    parameter int unsigned     DEPTH_NBITS = 4,
    parameter int unsigned     DEPTH       = 1 << DEPTH_NBITS,
    parameter int unsigned     WE_GRAN     = 8,
    parameter int unsigned     RD_LATENCY  = 1,
    parameter int unsigned     BYPASS      = 1,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         init_done,
    input  logic                         wr,
    input  logic [WIDTH/WE_GRAN-1:0]     wmask,
    input  logic [DEPTH_NBITS-1:0]       waddr,
    input  logic [WIDTH-1:0]             din,
    input  logic                         rd,
    input  logic [DEPTH_NBITS-1:0]       raddr,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid
);

    localparam int unsigned NLANES = WIDTH / WE_GRAN;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Elaboration-time parameter legality checks
    if ((WIDTH % WE_GRAN) != 0) begin : g_bad_gran
        $fatal(1, "ram_1r1w_ext: WIDTH must be a multiple of WE_GRAN");
    end
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_lat
        $fatal(1, "ram_1r1w_ext: RD_LATENCY must be 1 or 2");
    end
    if (DEPTH != (1 << DEPTH_NBITS)) begin : g_bad_depth
        $fatal(1, "ram_1r1w_ext: DEPTH must equal 1<<DEPTH_NBITS");
    end

    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]             state_q, state_d;
    logic [DEPTH_NBITS-1:0] init_cnt_q, init_cnt_d;
    logic                   init_done_q, init_done_d;
    logic [WIDTH-1:0]       dout_q;
    logic                   dout_valid_q;

    logic                   ready;
    logic                   rd_fire;
    logic [WIDTH-1:0]       rd_data;

    // Init FSM next-state logic
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = DEPTH_NBITS'(init_cnt_q + 1'b1);
                if (init_cnt_q == DEPTH_NBITS'(DEPTH - 1)) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            ST_READY: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Init FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign ready   = (state_q == ST_READY);
    assign rd_fire = rd && ready;

    // Array write: sweep word during INIT, masked user write once READY; nothing on a reset edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) begin
                mem_q[init_cnt_q] <= INIT_VAL;
            end else if (wr) begin
                for (int unsigned i = 0; i < NLANES; i++) begin
                    if (wmask[i]) begin
                        mem_q[waddr][i*WE_GRAN +: WE_GRAN] <= din[i*WE_GRAN +: WE_GRAN];
                    end
                end
            end
        end
    end

    // Read word, with per-lane forwarding of a same-edge write when BYPASS is set
    always_comb begin
        rd_data = mem_q[raddr];
        if ((BYPASS != 0) && wr && (waddr == raddr)) begin
            for (int unsigned i = 0; i < NLANES; i++) begin
                if (wmask[i]) begin
                    rd_data[i*WE_GRAN +: WE_GRAN] = din[i*WE_GRAN +: WE_GRAN];
                end
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_valid_q <= rd_fire;
                if (rd_fire) begin
                    dout_q <= rd_data;
                end
            end
        end
    end else begin : g_lat2
        // Stage 1 snapshots the array at the read edge, so later writes cannot leak in
        logic [WIDTH-1:0] p1_data_q;
        logic             p1_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                p1_data_q    <= '0;
                p1_valid_q   <= 1'b0;
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                p1_valid_q   <= rd_fire;
                dout_valid_q <= p1_valid_q;
                if (rd_fire) begin
                    p1_data_q <= rd_data;
                end
                if (p1_valid_q) begin
                    dout_q <= p1_data_q;
                end
            end
        end
    end

    assign init_done  = init_done_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ram_1r1w_ext.sv
// Bench for ram_1r1w_ext: two instances share stimulus, one with defaults
// (1-cycle latency, bypass on) and one with 2-cycle latency and bypass off.
// Expected read results, tagged with the cycle they must appear in, are queued
// when the read is driven and compared when that cycle's outputs are sampled.
module tb_ram_1r1w_ext;

    localparam int unsigned W  = 64;
    localparam int unsigned AW = 4;
    localparam int unsigned D  = 16;
    localparam int unsigned G  = 8;
    localparam int unsigned NL = W / G;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic [NL-1:0] wmask;
    logic [AW-1:0] waddr;
    logic [W-1:0]  din;
    logic          rd;
    logic [AW-1:0] raddr;

    logic          init_done1, init_done2;
    logic [W-1:0]  dout1, dout2;
    logic          dout_valid1, dout_valid2;

    always #5 clk = ~clk;

    ram_1r1w_ext u_dut1 (
        .clk(clk), .rst(rst), .init_done(init_done1),
        .wr(wr), .wmask(wmask), .waddr(waddr), .din(din),
        .rd(rd), .raddr(raddr), .dout(dout1), .dout_valid(dout_valid1)
    );

    ram_1r1w_ext #(.RD_LATENCY(2), .BYPASS(0)) u_dut2 (
        .clk(clk), .rst(rst), .init_done(init_done2),
        .wr(wr), .wmask(wmask), .waddr(waddr), .din(din),
        .rd(rd), .raddr(raddr), .dout(dout2), .dout_valid(dout_valid2)
    );

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    exp_t         q1[$];
    exp_t         q2[$];
    logic [W-1:0] mem_m [D];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           init_cnt_m = 0;
    bit           ready_m = 1'b0;
    bit           rst_prev = 1'b0;

    function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                           input logic [NL-1:0] m);
        logic [W-1:0] r;
        r = o;
        for (int i = 0; i < int'(NL); i++) begin
            if (m[i]) r[i*G +: G] = n[i*G +: G];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model for the coming edge, check the current outputs
    task automatic step(input logic r, input logic w, input logic [NL-1:0] m,
                        input logic [AW-1:0] wa, input logic [W-1:0] d,
                        input logic rv, input logic [AW-1:0] ra);
        bit           ready_n;
        logic [W-1:0] e1, e2;
        rst = r; wr = w; wmask = m; waddr = wa; din = d; rd = rv; raddr = ra;
        ready_n = ready_m;
        if (r) begin
            ready_n    = 1'b0;
            init_cnt_m = 0;
            while (q1.size() > 0 && q1[$].c >= cyc + 1) void'(q1.pop_back());
            while (q2.size() > 0 && q2[$].c >= cyc + 1) void'(q2.pop_back());
        end else if (!ready_m) begin
            mem_m[init_cnt_m] = '0;
            if (init_cnt_m == int'(D) - 1) ready_n = 1'b1;
            init_cnt_m++;
        end else begin
            if (rv) begin
                e1 = (w && wa == ra) ? merge(mem_m[ra], d, m) : mem_m[ra];
                q1.push_back('{d: e1, c: cyc + 1});
                q2.push_back('{d: mem_m[ra], c: cyc + 2});
            end
            if (w) mem_m[wa] = merge(mem_m[wa], d, m);
        end

        @(negedge clk);
        chk1("init_done1", init_done1, ready_m);
        chk1("init_done2", init_done2, ready_m);
        if (rst_prev) begin
            chk("dout1_reset", dout1, '0);
            chk("dout2_reset", dout2, '0);
        end
        if (q1.size() > 0 && q1[0].c == cyc) begin
            e1 = q1.pop_front().d;
            chk1("valid1", dout_valid1, 1'b1);
            chk("dout1", dout1, e1);
        end else begin
            chk1("valid1_idle", dout_valid1, 1'b0);
        end
        if (q2.size() > 0 && q2[0].c == cyc) begin
            e2 = q2.pop_front().d;
            chk1("valid2", dout_valid2, 1'b1);
            chk("dout2", dout2, e2);
        end else begin
            chk1("valid2_idle", dout_valid2, 1'b0);
        end

        @(posedge clk);
        cyc++;
        ready_m  = ready_n;
        rst_prev = r;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic run_init();
        int n;
        n = 0;
        while (!ready_m && n < 40) begin
            idle();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wa, ra;
        rst = 1'b1; wr = 1'b0; wmask = '0; waddr = '0; din = '0; rd = 1'b0; raddr = '0;
        @(posedge clk);
        #1;
        cyc = 1;
        rst_prev = 1'b1;

        // Reset held for a second cycle, then the sweep with ignored traffic at cycle 3
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        idle();
        idle();
        step(1'b0, 1'b1, 8'hFF, 4'd7, 64'h55, 1'b1, 4'd0);
        run_init();

        // Whole array reads back as INIT_VAL
        for (int i = 0; i < int'(D); i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(i));
        idle();

        // Full and partial-mask writes
        step(1'b0, 1'b1, 8'hFF, 4'd3, 64'h1111_1111_1111_1111, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd3);
        step(1'b0, 1'b1, 8'h0F, 4'd3, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd3);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd7);

        // Same-edge write/read, full and partial mask
        step(1'b0, 1'b1, 8'hFF, 4'd5, 64'hDEAD_BEEF_0000_0001, 1'b1, 4'd5);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd5);
        step(1'b0, 1'b1, 8'hFF, 4'd9, 64'h0123_4567_89AB_CDEF, 1'b0, '0);
        step(1'b0, 1'b1, 8'hF0, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd9);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd9);

        // Independent addresses on the same edge, and a zero-mask write
        step(1'b0, 1'b1, 8'hFF, 4'd10, 64'h77, 1'b1, 4'd3);
        step(1'b0, 1'b1, 8'h00, 4'd5, 64'h0, 1'b1, 4'd10);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd5);

        // Back-to-back reads with a write to the first address right after its read
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd3);
        step(1'b0, 1'b1, 8'hFF, 4'd3, 64'hC0FF_EE00_1234_5678, 1'b1, 4'd9);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd5);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd3);
        idle();
        idle();

        // Reset the cycle after a read, with a write coincident with the reset edge
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd3);
        step(1'b1, 1'b1, 8'hFF, 4'd4, 64'hBAD, 1'b0, '0);
        run_init();
        for (int i = 0; i < int'(D); i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(i));

        // Random mixed traffic, biased toward address collisions
        for (int i = 0; i < 40; i++) begin
            wa = AW'($urandom_range(0, 3));
            ra = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, 3));
            step(1'b0, 1'($urandom_range(0, 1)), NL'($urandom), wa,
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)), ra);
        end
        idle();
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_1r1w_ext.md
Name: ram_1r1w_ext

Overview:
- Parametrised successor to the team's plain 1R1W distributed-RAM model.
- Adds per-lane write masking, a read-enable with valid qualifier, selectable 1- or 2-cycle read latency, and optional same-address write-to-read bypass.
- Adds a self-clearing init sweep after reset, with an init_done status.
- Used as the storage primitive under table, FIFO and context-store blocks that need known contents after reset.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH_NBITS, 4, address width.
- DEPTH, 1<<DEPTH_NBITS, number of words; must equal 1<<DEPTH_NBITS.
- WE_GRAN, 8, bits per write-mask lane; WIDTH % WE_GRAN must be 0. NLANES = WIDTH/WE_GRAN.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- BYPASS, 1, 1 = read of an address being written on the same edge returns the new data; 0 = returns the old data.
- INIT_VAL, 0, WIDTH-bit value written to every word by the init sweep.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- init_done  output  1  high once the init sweep has completed.
- wr  input  1  write enable.
- wmask  input  NLANES  per-lane write enable; bit i covers din[i*WE_GRAN +: WE_GRAN].
- waddr  input  DEPTH_NBITS  write address.
- din  input  WIDTH  write data.
- rd  input  1  read enable.
- raddr  input  DEPTH_NBITS  read address.
- dout  output  WIDTH  read data.
- dout_valid  output  1  one-cycle pulse qualifying dout.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high; it is sampled only at posedge clk.
- Reset values: init_done=0, dout=0, dout_valid=0, all pipeline valid bits=0. Init FSM goes to INIT with init_cnt=0. The memory array is not reset directly; the sweep clears it.
- FSM, INIT state:
  - Each edge with rst low writes INIT_VAL to mem[init_cnt] and increments init_cnt.
  - On the edge that writes init_cnt==DEPTH-1, the FSM moves to READY and init_done is registered high.
  - The first usable cycle is therefore DEPTH edges after rst is sampled low.
- FSM, READY state: stays in READY until rst. init_done stays high.
- Accesses during INIT: wr and rd are ignored. No user write reaches the array and no dout_valid is generated.
- Write (READY):
  - wr=1 at an edge updates only the lanes of mem[waddr] whose wmask bit is 1.
  - wr=1 with wmask=0 is a no-op.
- Read (READY), rd=1 sampled at edge N:
  - RD_LATENCY=1: dout and dout_valid=1 are updated at edge N, visible in cycle N+1.
  - RD_LATENCY=2: an extra output register; dout_valid=1 and data are visible in cycle N+2.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- dout holds its last value when no read completes. dout_valid is 1 for exactly one cycle per accepted read.
- Same edge, wr=1, rd=1, waddr==raddr:
  - BYPASS=1: each returned lane comes from din if its wmask bit is 1, otherwise from the old word.
  - BYPASS=0: the whole old word is returned.
  - The write always completes.
- With RD_LATENCY=2, a write in the cycle after the read does not alter that read's data; the data is a snapshot of the array at edge N.
- Write and read to different addresses on the same edge are independent.
- rst asserted mid-operation:
  - In-flight reads are discarded; dout_valid is 0 from the next edge.
  - dout returns to 0 and init_done drops.
  - The sweep restarts from address 0. A write coincident with the rst edge is dropped.
- rst held high for multiple cycles keeps init_cnt=0. The sweep begins only once rst is sampled low.
- Illegal parameters (WIDTH % WE_GRAN != 0, RD_LATENCY not in {1,2}, DEPTH != 1<<DEPTH_NBITS) raise a fatal error at elaboration or time 0.
- Storage carries the distributed-RAM style attribute; the output registers are flops.

Test Plan:
- Defaults, pulse rst for 1 cycle → init_done rises exactly 16 edges after rst is sampled low. Reads of addresses 0..15 then return 0 with one dout_valid pulse each, 1-cycle latency.
- wr addr 3, din=0x1111_1111_1111_1111, wmask=0xFF; rd addr 3 next cycle → dout=0x1111_1111_1111_1111, dout_valid for one cycle.
- Then wr addr 3, din=0xAAAA_AAAA_AAAA_AAAA, wmask=0x0F; rd addr 3 → dout=0x1111_1111_AAAA_AAAA.
- Same-edge wr/rd addr 5 (old 0, din=0xDEAD_BEEF_0000_0001, wmask=0xFF) → BYPASS=1 returns 0xDEAD_BEEF_0000_0001; BYPASS=0 returns 0. A following rd returns the new value in both cases.
- During INIT, rd at cycle 3 and wr addr 7 din=0x55 → no dout_valid. After init_done, addr 7 reads 0.
- RD_LATENCY=2: issue rd on 4 consecutive cycles → 4 consecutive dout_valid pulses starting 2 cycles later, in order. Assert rst the cycle after a rd → that read never produces dout_valid, dout=0, and the sweep re-zeroes the memory.
